// File: rtl/oam_sprite_dma.sv
// $4014 OAM DMA: stalls the CPU and copies one 256-byte CPU page into OAM from OAMADDR.
// 513 CPU cycles per transfer; 514 on odd starts when OAM_DMA_ODD_ALIGN_EN is defined.
module oam_sprite_dma #(
  parameter int OAM_AW = 8,
  parameter int CPU_AW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_clk_en,
  input  logic              reg_wr,
  input  logic [7:0]        reg_wdata,
  input  logic [OAM_AW-1:0] oamaddr_in,
  input  logic              cpu_odd,
  output logic              cpu_rdy,
  output logic [CPU_AW-1:0] mem_addr,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic [OAM_AW-1:0] oam_addr,
  output logic              oam_we,
  output logic [7:0]        oam_wdata,
  output logic              dma_busy,
  output logic              dma_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DUMMY,
    S_READ,
    S_WRITE
`ifdef OAM_DMA_ODD_ALIGN_EN
    , S_ALIGN
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        page_q, page_d;
  logic [OAM_AW-1:0] cnt_q, cnt_d;
  logic [OAM_AW-1:0] oam_addr_q, oam_addr_d;
  logic [7:0]        oam_wdata_q, oam_wdata_d;
  logic              done_q, done_d;

`ifndef OAM_DMA_ODD_ALIGN_EN
  logic odd_unused;
  assign odd_unused = cpu_odd;
`endif

  always_comb begin
    state_d     = state_q;
    page_d      = page_q;
    cnt_d       = cnt_q;
    oam_addr_d  = oam_addr_q;
    oam_wdata_d = oam_wdata_q;
    done_d      = 1'b0;
    if (cpu_clk_en) begin
      case (state_q)
        S_IDLE: begin
          if (reg_wr) begin
            page_d     = reg_wdata;
            oam_addr_d = oamaddr_in;
            cnt_d      = '0;
            state_d    = S_DUMMY;
          end
        end
        S_DUMMY: begin
`ifdef OAM_DMA_ODD_ALIGN_EN
          state_d = cpu_odd ? S_ALIGN : S_READ;
`else
          state_d = S_READ;
`endif
        end
`ifdef OAM_DMA_ODD_ALIGN_EN
        S_ALIGN: state_d = S_READ;
`endif
        S_READ: begin
          oam_wdata_d = mem_rdata;
          state_d     = S_WRITE;
        end
        S_WRITE: begin
          // OAM address wraps freely; the byte count alone decides termination
          oam_addr_d = oam_addr_q + OAM_AW'(1);
          cnt_d      = cnt_q + OAM_AW'(1);
          if (&cnt_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_READ;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      page_q      <= '0;
      cnt_q       <= '0;
      oam_addr_q  <= '0;
      oam_wdata_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      page_q      <= page_d;
      cnt_q       <= cnt_d;
      oam_addr_q  <= oam_addr_d;
      oam_wdata_q <= oam_wdata_d;
      done_q      <= done_d;
    end
  end

  // Status decoded straight from state so reset releases the CPU asynchronously
  assign cpu_rdy   = (state_q == S_IDLE);
  assign dma_busy  = (state_q != S_IDLE);
  assign mem_re    = (state_q == S_READ);
  assign oam_we    = (state_q == S_WRITE);
  assign mem_addr  = CPU_AW'({page_q, cnt_q});
  assign oam_addr  = oam_addr_q;
  assign oam_wdata = oam_wdata_q;
  assign dma_done  = done_q;

endmodule

// File: tb/tb_oam_sprite_dma.sv
// Scoreboard bench for oam_sprite_dma: expected OAM writes are queued at DMA issue and
// popped by a monitor on every committed oam_we tick.
module tb_oam_sprite_dma;
  localparam int OAM_AW = 8;
  localparam int CPU_AW = 16;
`ifdef OAM_DMA_ODD_ALIGN_EN
  localparam bit ALIGN_ON = 1'b1;
`else
  localparam bit ALIGN_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cpu_clk_en = 1'b0;
  logic              reg_wr = 1'b0;
  logic [7:0]        reg_wdata = 8'h00;
  logic [OAM_AW-1:0] oamaddr_in = '0;
  logic              cpu_odd = 1'b0;
  logic              cpu_rdy;
  logic [CPU_AW-1:0] mem_addr;
  logic              mem_re;
  logic [7:0]        mem_rdata;
  logic [OAM_AW-1:0] oam_addr;
  logic              oam_we;
  logic [7:0]        oam_wdata;
  logic              dma_busy;
  logic              dma_done;

  oam_sprite_dma #(.OAM_AW(OAM_AW), .CPU_AW(CPU_AW)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_clk_en(cpu_clk_en), .reg_wr(reg_wr),
    .reg_wdata(reg_wdata), .oamaddr_in(oamaddr_in), .cpu_odd(cpu_odd),
    .cpu_rdy(cpu_rdy), .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .oam_addr(oam_addr), .oam_we(oam_we), .oam_wdata(oam_wdata),
    .dma_busy(dma_busy), .dma_done(dma_done)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [0:65535];
  assign mem_rdata = ram[mem_addr];

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;
  wr_t exp_q[$];

  logic [7:0] oam [0:255];
  logic [7:0] exp_oam [0:255];
  int checks = 0;
  int errors = 0;
  int wr_cnt, stall_cnt, done_cnt, tick_idx, first_re;
  bit tracking = 1'b0;
  int en_mode = 0;
  int ph = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // CPU clock enable pattern: continuous, every 3rd clk, or random
  initial forever begin
    @(posedge clk);
    #1;
    case (en_mode)
      0: cpu_clk_en = 1'b1;
      1: begin cpu_clk_en = (ph == 0); ph = (ph + 1) % 3; end
      default: cpu_clk_en = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: samples on the falling edge, i.e. the values the next rising edge commits
  logic [35:0] prev_obs;
  logic        prev_en;
  bit          prev_vld = 1'b0;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      prev_vld = 1'b0;
    end else begin
      if (prev_vld && !prev_en)
        chk("hold_when_disabled",
            {mem_addr, mem_re, oam_we, oam_addr, oam_wdata, cpu_rdy, dma_busy}, prev_obs);
      if (dma_done) done_cnt++;
      if (cpu_clk_en) begin
        if (!cpu_rdy) stall_cnt++;
        if (tracking) begin
          tick_idx++;
          if (mem_re && first_re < 0) first_re = tick_idx;
        end
        if (reg_wr && cpu_rdy) begin
          tracking = 1'b1;
          tick_idx = 0;
          first_re = -1;
        end
        if (oam_we) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write actual=%0h/%0h required=none", oam_addr, oam_wdata);
          end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("oam_addr", oam_addr, e.a);
            chk("oam_wdata", oam_wdata, e.d);
            exp_oam[e.a] = e.d;
          end
          oam[oam_addr] = oam_wdata;
          wr_cnt++;
        end
      end
      prev_obs = {mem_addr, mem_re, oam_we, oam_addr, oam_wdata, cpu_rdy, dma_busy};
      prev_en  = cpu_clk_en;
      prev_vld = 1'b1;
    end
  end

  task automatic prep();
    for (int i = 0; i < 256; i++) begin
      oam[i]     = 8'h5A;
      exp_oam[i] = 8'h5A;
    end
    stall_cnt = 0;
    done_cnt  = 0;
    wr_cnt    = 0;
    first_re  = -1;
    tracking  = 1'b0;
  endtask

  task automatic wait_en_slot();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (!cpu_clk_en && n < 200);
    if (!cpu_clk_en) begin
      checks++;
      errors++;
      $display("FAIL en_slot_timeout actual=0 required=1");
    end
  endtask

  task automatic start_dma(input logic [7:0] page, input logic [7:0] start);
    wait_en_slot();
    reg_wr     = 1'b1;
    reg_wdata  = page;
    oamaddr_in = start;
    for (int i = 0; i < 256; i++) begin
      wr_t e;
      logic [7:0] b;
      b   = 8'(i);
      e.a = start + b;
      e.d = ram[{page, b}];
      exp_q.push_back(e);
    end
    @(posedge clk);
    #2;
    reg_wr     = 1'b0;
    oamaddr_in = 8'($urandom);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_cnt == 0 && n < 6000) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt == 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=0 required=1");
    end
    repeat (4) @(posedge clk);
    #2;
  endtask

  task automatic check_oam(input string tag);
    for (int i = 0; i < 256; i++)
      chk($sformatf("%s_oam[%0d]", tag, i), oam[i], exp_oam[i]);
  endtask

  task automatic run_case(input string tag, input logic [7:0] page, input logic [7:0] start,
                          input int mode, input int exp_stall);
    prep();
    en_mode = mode;
    start_dma(page, start);
    wait_done();
    chk({tag, "_stall"}, stall_cnt, exp_stall);
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_writes"}, wr_cnt, 256);
    chk({tag, "_queue_left"}, exp_q.size(), 0);
    chk({tag, "_rdy_after"}, cpu_rdy, 1'b1);
    check_oam(tag);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    prep();

    repeat (3) @(posedge clk);
    #2;
    chk("rst_cpu_rdy", cpu_rdy, 1'b1);
    chk("rst_dma_busy", dma_busy, 1'b0);
    chk("rst_dma_done", dma_done, 1'b0);
    chk("rst_mem_re", mem_re, 1'b0);
    chk("rst_oam_we", oam_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_oam_addr", oam_addr, 8'h00);
    chk("rst_oam_wdata", oam_wdata, 8'h00);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Basic copy from page 2
    for (int i = 0; i < 256; i++) ram[16'h0200 + i] = 8'(i) ^ 8'hA5;
    run_case("basic", 8'h02, 8'h00, 0, 513);
    chk("basic_first_re_tick", first_re, 2);

    // OAM address wrap
    for (int i = 0; i < 256; i++) ram[16'h0300 + i] = 8'(i);
    run_case("wrap", 8'h03, 8'hFC, 0, 513);
    chk("wrap_oam_fc", oam[8'hFC], 8'h00);
    chk("wrap_oam_ff", oam[8'hFF], 8'h03);
    chk("wrap_oam_00", oam[8'h00], 8'h04);
    chk("wrap_oam_fb", oam[8'hFB], 8'hFF);

    // Re-trigger during the 100th write is ignored
    for (int i = 0; i < 256; i++) ram[16'h0500 + i] = 8'(i) ^ 8'h3C;
    prep();
    en_mode = 0;
    start_dma(8'h02, 8'h00);
    n = 0;
    while (wr_cnt < 99 && n < 2000) begin @(posedge clk); n++; end
    #2;
    @(posedge clk);
    #2;
    chk("retrig_in_write", oam_we, 1'b1);
    reg_wr     = 1'b1;
    reg_wdata  = 8'h05;
    oamaddr_in = 8'h10;
    @(posedge clk);
    #2;
    reg_wr = 1'b0;
    wait_done();
    repeat (50) @(posedge clk);
    #2;
    chk("retrig_busy_after", dma_busy, 1'b0);
    chk("retrig_done_pulses", done_cnt, 1);
    chk("retrig_writes", wr_cnt, 256);
    check_oam("retrig");

    // Reset after 40 bytes
    prep();
    en_mode = 0;
    start_dma(8'h02, 8'h00);
    n = 0;
    while (wr_cnt < 40 && n < 2000) begin @(posedge clk); n++; end
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_cpu_rdy", cpu_rdy, 1'b1);
    chk("rst_mid_oam_we", oam_we, 1'b0);
    chk("rst_mid_dma_busy", dma_busy, 1'b0);
    chk("rst_mid_mem_re", mem_re, 1'b0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    chk("rst_mid_writes", wr_cnt, 40);
    chk("rst_mid_done_pulses", done_cnt, 0);
    check_oam("rst_mid");

    // Throttled CPU clock
    run_case("throttle", 8'h02, 8'h00, 1, 513);

    // Odd start alignment
    cpu_odd = 1'b1;
    run_case("odd", 8'h02, 8'h00, 0, ALIGN_ON ? 514 : 513);
    chk("odd_first_re_tick", first_re, ALIGN_ON ? 3 : 2);
    cpu_odd = 1'b0;

    // Randomized transfers
    for (int t = 0; t < 3; t++) begin
      logic [7:0] pg;
      logic [7:0] st;
      int md;
      pg = 8'($urandom);
      st = 8'($urandom);
      md = $urandom_range(0, 2);
      cpu_odd = 1'($urandom_range(0, 1));
      for (int i = 0; i < 256; i++) ram[{pg, 8'(i)}] = 8'($urandom);
      run_case($sformatf("rand%0d", t), pg, st, md, (ALIGN_ON && cpu_odd) ? 514 : 513);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
